// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: default frame geometry, idle line level and the
// one-hot receive state encoding used by both transmitter and receiver.
package uart_receiver_pkg;

  localparam int   WORD_SIZE_DEF  = 8;
  localparam int   OVERSAMPLE_DEF = 16;
  localparam logic LINE_IDLE      = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_STARTING  = 4'b0010,
    ST_RECEIVING = 4'b0100,
    ST_STOP      = 4'b1000
  } uart_state_t;

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// level so a reset never looks like a start bit.
module input_synchronizer
  import uart_receiver_pkg::*;
(
  input  logic Clock,
  input  logic reset_,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge Clock) begin
    if (reset_) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit validation at half a bit, data and stop
// sampled at bit centres, with framing and overrun flags held until read_ack.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int word_size  = WORD_SIZE_DEF,
  parameter int oversample = OVERSAMPLE_DEF
) (
  input  logic                 Clock,
  input  logic                 reset_,
  input  logic                 Serial_in,
  input  logic                 sample_tick,
  input  logic                 read_ack,
  output logic [word_size-1:0] RCV_datareg,
  output logic                 Data_ready,
  output logic                 Error1,
  output logic                 Error2
);

  localparam int SC_W = $clog2(oversample);
  localparam int BC_W = $clog2(word_size + 1);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(oversample / 2 - 1);
  localparam logic [SC_W-1:0] SC_FULL = SC_W'(oversample - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(word_size - 1);

  logic                 w_line;
  uart_state_t          r_state;
  uart_state_t          w_next_state;
  logic [SC_W-1:0]      r_sample_count;
  logic [BC_W-1:0]      r_bit_count;
  logic [word_size-1:0] r_shift;
  logic [word_size-1:0] r_datareg;
  logic                 r_data_ready;
  logic                 r_error1;
  logic                 r_error2;
  logic                 w_at_half;
  logic                 w_at_full;
  logic                 w_clr_sample;
  logic                 w_inc_sample;
  logic                 w_clr_bits;
  logic                 w_shift_en;
  logic                 w_done;

  input_synchronizer u_sync (
    .Clock   (Clock),
    .reset_  (reset_),
    .i_async (Serial_in),
    .o_sync  (w_line)
  );

  assign w_at_half = (r_sample_count == SC_HALF);
  assign w_at_full = (r_sample_count == SC_FULL);

  always_ff @(posedge Clock) begin
    if (reset_) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (sample_tick && w_line != LINE_IDLE) w_next_state = ST_STARTING;
      ST_STARTING:  if (sample_tick && w_at_half)
                      w_next_state = (w_line == LINE_IDLE) ? ST_IDLE : ST_RECEIVING;
      ST_RECEIVING: if (sample_tick && w_at_full && r_bit_count == BC_LAST)
                      w_next_state = ST_STOP;
      ST_STOP:      if (sample_tick && w_at_full) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Datapath controls; everything is gated by sample_tick so state holds between ticks.
  always_comb begin
    w_clr_sample = 1'b0;
    w_inc_sample = 1'b0;
    w_clr_bits   = 1'b0;
    w_shift_en   = 1'b0;
    w_done       = 1'b0;
    if (sample_tick) begin
      case (r_state)
        ST_IDLE:      w_clr_sample = (w_line != LINE_IDLE);
        ST_STARTING:  begin
                        w_clr_sample = w_at_half;
                        w_clr_bits   = w_at_half;
                        w_inc_sample = !w_at_half;
                      end
        ST_RECEIVING: begin
                        w_shift_en   = w_at_full;
                        w_clr_sample = w_at_full;
                        w_inc_sample = !w_at_full;
                      end
        ST_STOP:      begin
                        w_done       = w_at_full;
                        w_clr_sample = w_at_full;
                        w_inc_sample = !w_at_full;
                      end
        default:      ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset_) begin
      r_sample_count <= '0;
      r_bit_count    <= '0;
      r_shift        <= '0;
      r_datareg      <= '0;
      r_data_ready   <= 1'b0;
      r_error1       <= 1'b0;
      r_error2       <= 1'b0;
    end else begin
      if (w_clr_sample)      r_sample_count <= '0;
      else if (w_inc_sample) r_sample_count <= r_sample_count + 1'b1;

      if (w_clr_bits)        r_bit_count <= '0;
      else if (w_shift_en)   r_bit_count <= r_bit_count + 1'b1;

      if (w_shift_en) r_shift <= {w_line, r_shift[word_size-1:1]};

      // A completing frame beats a coincident read_ack.
      if (w_done) begin
        r_datareg    <= r_shift;
        r_data_ready <= 1'b1;
        r_error1     <= (w_line != LINE_IDLE);
        r_error2     <= r_data_ready && !read_ack;
      end else if (read_ack) begin
        r_data_ready <= 1'b0;
        r_error1     <= 1'b0;
        r_error2     <= 1'b0;
      end
    end
  end

  assign RCV_datareg = r_datareg;
  assign Data_ready  = r_data_ready;
  assign Error1      = r_error1;
  assign Error2      = r_error2;

endmodule
